// File: rtl/bcd_timer_chain_if.sv
// Control and data bundle between the microwave timer FSM and the BCD down-counter.
// The master side drives load/count strobes; the slave side returns the count and status.
interface bcd_timer_chain_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  loadn;
  logic                  tick;
  logic [4*DIGITS-1:0]   data_in;
  logic [4*DIGITS-1:0]   data_out;
  logic                  zero;
  logic                  tc;
  logic                  done;

  modport master (
    output enable, loadn, tick, data_in,
    input  data_out, zero, tc, done
  );

  modport slave (
    input  enable, loadn, tick, data_in,
    output data_out, zero, tc, done
  );
endinterface

// File: rtl/bcd_timer_chain.sv
// Multi-digit BCD down-counter with optional mm:ss digit 1, clamp-on-load and hold/wrap at zero.
// Replaces a chain of single-digit decade counters with one single-cycle borrow network.
module bcd_timer_chain #(
  parameter int DIGITS = 4,
  parameter int MMSS   = 1,
  parameter int WRAP   = 0
) (
  input  logic              clock,
  input  logic              clear,
  bcd_timer_chain_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  function automatic logic [3:0] digit_max(input int i);
    return (MMSS == 1 && DIGITS >= 2 && i == 1) ? 4'd5 : 4'd9;
  endfunction

  logic [W-1:0] count_q;
  logic         done_q;
  logic [W-1:0] load_val;
  logic [W-1:0] dec_val;
  logic         all_zero;
  logic         borrow;
  logic [3:0]   d_in;
  logic [3:0]   d_cur;

  assign all_zero = (count_q == '0);

  // A digit borrows only when every lower digit is already zero; digit 0 always borrows.
  always_comb begin
    load_val = '0;
    dec_val  = '0;
    borrow   = 1'b1;
    d_in     = '0;
    d_cur    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d_in  = bus.data_in[4*i +: 4];
      d_cur = count_q[4*i +: 4];
      load_val[4*i +: 4] = (d_in > digit_max(i)) ? digit_max(i) : d_in;
      if (borrow) begin
        dec_val[4*i +: 4] = (d_cur == 4'd0) ? digit_max(i) : (d_cur - 4'd1);
      end else begin
        dec_val[4*i +: 4] = d_cur;
      end
      borrow = borrow & (d_cur == 4'd0);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.enable) begin
        if (!bus.loadn) begin
          count_q <= load_val;
        end else if (bus.tick) begin
          if (!all_zero) begin
            count_q <= dec_val;
            done_q  <= (dec_val == '0);
          end else if (WRAP != 0) begin
            count_q <= dec_val;
          end
        end
      end
    end
  end

  assign bus.data_out = count_q;
  assign bus.zero     = all_zero;
  assign bus.tc       = all_zero & bus.enable & bus.loadn & bus.tick;
  assign bus.done     = done_q;
endmodule
